// File: rtl/pipe_stage_chain_if.sv
// pipe_stage_chain_if: valid/ready/data stream bundle; master drives valid/data, slave drives ready
interface pipe_stage_chain_if #(
  parameter int WIDTH = 32
);
  logic             valid;
  logic             ready;
  logic [WIDTH-1:0] data;
  modport master (output valid, output data, input ready);
  modport slave (input valid, input data, output ready);
endinterface

// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: elastic valid/ready register chain with bubble collapsing, flush and occupancy; PIPE_SKID_EN adds a registered-ready input skid slot
module pipe_stage_chain #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  pipe_stage_chain_if.slave           up,
  pipe_stage_chain_if.master          dn,
  input  logic                        flush,
  output logic [$clog2(DEPTH+2)-1:0]  occupancy
);
  localparam int OW = $clog2(DEPTH+2);
  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] cv;
  logic [WIDTH-1:0] d [DEPTH];
  logic [WIDTH-1:0] cd [DEPTH];
  logic             src_v;
  logic [WIDTH-1:0] src_d;
  logic             push;
  logic             pop;
  // a stage may load whenever some stage between it and the output is empty, or the output drains
  for (genvar g = 0; g < DEPTH; g++) begin : g_adv
    assign adv[g] = !(&v[DEPTH-1:g]) | dn.ready;
  end
  // predecessor of stage 0 is the input side, of stage g the stage g-1
  if (DEPTH > 1) begin : g_chain
    assign cv = {v[DEPTH-2:0], src_v};
  end else begin : g_single
    assign cv = src_v;
  end
  assign cd[0] = src_d;
  for (genvar g = 1; g < DEPTH; g++) begin : g_cd
    assign cd[g] = d[g-1];
  end
`ifdef PIPE_SKID_EN
  logic             skid_v;
  logic             rdy;
  logic [WIDTH-1:0] skid_d;
  assign up.ready = rdy & !flush;
  assign push     = up.valid & up.ready;
  assign src_v    = skid_v | push;
  assign src_d    = skid_v ? skid_d : up.data;
  // a parked word always drains first; ready is registered off the slot's next state
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      skid_v <= 1'b0;
      skid_d <= '0;
      rdy    <= 1'b0;
    end else begin
      skid_v <= !flush & (skid_v | push) & !adv[0];
      if (push & !adv[0]) skid_d <= up.data;
      rdy    <= !flush & !((skid_v | push) & !adv[0]);
    end
`else
  assign up.ready = adv[0] & !flush;
  assign push     = up.valid & up.ready;
  assign src_v    = up.valid;
  assign src_d    = up.data;
`endif
  assign dn.valid = v[DEPTH-1];
  assign dn.data  = d[DEPTH-1];
  assign pop      = dn.valid & dn.ready & !flush;
  // valid bits follow their predecessor on advance; flush empties the whole chain
  always_ff @(posedge clk or negedge rst)
    if (!rst) v <= '0;
    else v <= flush ? '0 : (adv & cv) | (~adv & v);
  // data loads only with a valid incoming word, so an emptied stage keeps stale contents
  always_ff @(posedge clk or negedge rst)
    if (!rst) for (int i = 0; i < DEPTH; i++) d[i] <= '0;
    else for (int i = 0; i < DEPTH; i++) if (adv[i] & cv[i]) d[i] <= cd[i];
  // occupancy tracks transfers in and out, so it always equals the held entry count
  always_ff @(posedge clk or negedge rst)
    if (!rst) occupancy <= '0;
    else occupancy <= flush ? '0 : occupancy + OW'(push) - OW'(pop);
endmodule
